// File: rtl/apb_req_arbiter_if.sv
// Bundle of upstream requester APB lanes and the single downstream APB lane.
// Latency: none, wiring only.
// Backpressure: carried by the PREADY signals in each direction.
interface apb_req_arbiter_if #(
    parameter int NB_REQ         = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic [NB_REQ-1:0]                     req_psel_i;
    logic [NB_REQ-1:0]                     req_penable_i;
    logic [NB_REQ-1:0]                     req_pwrite_i;
    logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0] req_paddr_i;
    logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0] req_pwdata_i;
    logic [APB_DATA_WIDTH-1:0]             req_prdata_o;
    logic [NB_REQ-1:0]                     req_pready_o;
    logic [NB_REQ-1:0]                     req_pslverr_o;

    logic                                  apb_psel_o;
    logic                                  apb_penable_o;
    logic                                  apb_pwrite_o;
    logic [APB_ADDR_WIDTH-1:0]             apb_paddr_o;
    logic [APB_DATA_WIDTH-1:0]             apb_pwdata_o;
    logic [APB_DATA_WIDTH-1:0]             apb_prdata_i;
    logic                                  apb_pready_i;
    logic                                  apb_pslverr_i;

    // Arbiter view.
    modport slave (
        input  req_psel_i, req_penable_i, req_pwrite_i, req_paddr_i, req_pwdata_i,
        output req_prdata_o, req_pready_o, req_pslverr_o,
        output apb_psel_o, apb_penable_o, apb_pwrite_o, apb_paddr_o, apb_pwdata_o,
        input  apb_prdata_i, apb_pready_i, apb_pslverr_i
    );

    // Environment view: requesters plus downstream peripheral.
    modport master (
        output req_psel_i, req_penable_i, req_pwrite_i, req_paddr_i, req_pwdata_i,
        input  req_prdata_o, req_pready_o, req_pslverr_o,
        input  apb_psel_o, apb_penable_o, apb_pwrite_o, apb_paddr_o, apb_pwdata_o,
        output apb_prdata_i, apb_pready_i, apb_pslverr_i
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin share of one APB bus among NB_REQ requesters, one transfer in flight.
// Latency: psel at T -> SETUP T+1 -> ACCESS T+2.. -> registered req_pready one cycle after PREADY.
// Backpressure: requesters wait on req_pready; slave stalls via PREADY, bounded by TIMEOUT_CYC.
module apb_req_arbiter #(
    parameter int NB_REQ         = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYC    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    apb_req_arbiter_if.slave      bus,
    output logic [NB_REQ-1:0]     grant_o,
    output logic                  timeout_o
);
    localparam int PW = $clog2(NB_REQ);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [CW-1:0]     to_cnt;
    logic              win_vld;
    logic [PW-1:0]     win_idx;
    logic [NB_REQ-1:0] win_onehot;
    int                cand;

    // Scan from the index after the last winner, wrapping, and take the first pending.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int off = 1; off <= NB_REQ; off++) begin
            cand = (int'(rr_ptr) + off) % NB_REQ;
            if (!win_vld && bus.req_psel_i[cand]) begin
                win_vld = 1'b1;
                win_idx = PW'(cand);
            end
        end
        win_onehot = NB_REQ'(1) << win_idx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state             <= ST_IDLE;
            rr_ptr            <= PW'(NB_REQ - 1);
            to_cnt            <= '0;
            grant_o           <= '0;
            timeout_o         <= 1'b0;
            bus.apb_psel_o    <= 1'b0;
            bus.apb_penable_o <= 1'b0;
            bus.apb_pwrite_o  <= 1'b0;
            bus.apb_paddr_o   <= '0;
            bus.apb_pwdata_o  <= '0;
            bus.req_prdata_o  <= '0;
            bus.req_pready_o  <= '0;
            bus.req_pslverr_o <= '0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        grant_o           <= win_onehot;
                        rr_ptr            <= win_idx;
                        bus.apb_pwrite_o  <= bus.req_pwrite_i[win_idx];
                        bus.apb_paddr_o   <= bus.req_paddr_i[win_idx];
                        bus.apb_pwdata_o  <= bus.req_pwdata_i[win_idx];
                        bus.apb_psel_o    <= 1'b1;
                        bus.apb_penable_o <= 1'b0;
                        state             <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    bus.apb_penable_o <= 1'b1;
                    to_cnt            <= '0;
                    state             <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY takes priority over a timeout landing in the same cycle.
                    if (bus.apb_pready_i) begin
                        bus.apb_psel_o    <= 1'b0;
                        bus.apb_penable_o <= 1'b0;
                        bus.req_pready_o  <= grant_o;
                        bus.req_pslverr_o <= bus.apb_pslverr_i ? grant_o : '0;
                        bus.req_prdata_o  <= bus.apb_prdata_i;
                        state             <= ST_RESP;
                    end else if ((TIMEOUT_CYC != 0) && (to_cnt == TO_LAST)) begin
                        bus.apb_psel_o    <= 1'b0;
                        bus.apb_penable_o <= 1'b0;
                        bus.req_pready_o  <= grant_o;
                        bus.req_pslverr_o <= grant_o;
                        bus.req_prdata_o  <= '0;
                        timeout_o         <= 1'b1;
                        state             <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    bus.req_pready_o  <= '0;
                    bus.req_pslverr_o <= '0;
                    grant_o           <= '0;
                    state             <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a response scoreboard and a simple APB slave.
module tb_apb_req_arbiter;
    localparam int NB = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] grant;
    logic          timeout;

    always #5 clk = ~clk;

    apb_req_arbiter_if #(.NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

    apb_req_arbiter #(
        .NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus.slave), .grant_o(grant), .timeout_o(timeout)
    );

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc;
    logic [31:0] addr_hold;

    // Slave model: returns address XOR mask after slv_wait stall cycles.
    logic [31:0] slv_mask = 32'h5A5A_0F0F;
    int          slv_wait = 0;
    logic        slv_err = 1'b0;
    int          acc_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int i, input logic sel, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        bus.req_psel_i[i]    = sel;
        bus.req_penable_i[i] = 1'b0;
        bus.req_pwrite_i[i]  = wr;
        bus.req_paddr_i[i]   = a;
        bus.req_pwdata_i[i]  = d;
    endtask

    task automatic push_exp(input int i, input logic [31:0] rd, input logic er, input logic t);
        exp_t x;
        x.idx = i; x.rdata = rd; x.err = er; x.to = t;
        exp_q.push_back(x);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_psel"},    bus.apb_psel_o, 0);
        chk({tag, "_penable"}, bus.apb_penable_o, 0);
        chk({tag, "_pwrite"},  bus.apb_pwrite_o, 0);
        chk({tag, "_paddr"},   bus.apb_paddr_o, 0);
        chk({tag, "_pwdata"},  bus.apb_pwdata_o, 0);
        chk({tag, "_prdata"},  bus.req_prdata_o, 0);
        chk({tag, "_pready"},  bus.req_pready_o, 0);
        chk({tag, "_pslverr"}, bus.req_pslverr_o, 0);
        chk({tag, "_grant"},   grant, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic wait_resp(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_pready_o == '0 && n < max);
        chk("resp_bound", |bus.req_pready_o, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.apb_pready_i  = 1'b0;
        bus.apb_prdata_i  = '0;
        bus.apb_pslverr_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.apb_psel_o && bus.apb_penable_o) begin
                if (acc_cnt == slv_wait) begin
                    bus.apb_pready_i  = 1'b1;
                    bus.apb_prdata_i  = bus.apb_paddr_o ^ slv_mask;
                    bus.apb_pslverr_i = slv_err;
                end else begin
                    bus.apb_pready_i  = 1'b0;
                    bus.apb_prdata_i  = 32'hBAD0_0000;
                    bus.apb_pslverr_i = 1'b1;
                end
                acc_cnt++;
            end else begin
                acc_cnt           = 0;
                bus.apb_pready_i  = 1'b0;
                bus.apb_pslverr_i = 1'b0;
            end
        end
    end

    // Scoreboard: every upstream response is matched against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rdy_not_granted", bus.req_pready_o & ~grant, 0);
                if (|bus.req_pready_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", bus.req_pready_o, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_idx",     bus.req_pready_o, 1 << e.idx);
                        chk("resp_rdata",   bus.req_prdata_o, e.rdata);
                        chk("resp_err",     bus.req_pslverr_o, e.err ? (1 << e.idx) : 0);
                        chk("resp_timeout", timeout, e.to);
                    end
                end else begin
                    chk("slverr_idle",  bus.req_pslverr_o, 0);
                    chk("timeout_idle", timeout, 0);
                end
            end
        end
    end

    initial begin
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Single write with zero wait states.
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 32'h1A10_0008, 32'hDEAD_BEEF);
        push_exp(0, 32'h1A10_0008 ^ slv_mask, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_setup_psel",    bus.apb_psel_o, 1);
        chk("t1_setup_penable", bus.apb_penable_o, 0);
        chk("t1_setup_grant",   grant, 2'b01);
        chk("t1_paddr",         bus.apb_paddr_o, 32'h1A10_0008);
        chk("t1_pwdata",        bus.apb_pwdata_o, 32'hDEAD_BEEF);
        chk("t1_pwrite",        bus.apb_pwrite_o, 1);
        @(negedge clk);
        chk("t1_access_psel",    bus.apb_psel_o, 1);
        chk("t1_access_penable", bus.apb_penable_o, 1);
        @(negedge clk);
        chk("t1_resp_pready", bus.req_pready_o, 2'b01);
        chk("t1_resp_psel",   bus.apb_psel_o, 0);
        set_req(0, 1'b0, 1'b0, '0, '0);

        // Contention from reset: round-robin grants 0,1,0,1.
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, '0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0200, '0);
        push_exp(0, 32'h0000_0100 ^ slv_mask, 1'b0, 1'b0);
        push_exp(1, 32'h0000_0200 ^ slv_mask, 1'b0, 1'b0);
        push_exp(0, 32'h0000_0100 ^ slv_mask, 1'b0, 1'b0);
        push_exp(1, 32'h0000_0200 ^ slv_mask, 1'b0, 1'b0);
        wait_resp(20, cyc);
        chk("t2_first_lat", cyc, 3);
        for (int k = 0; k < 3; k++) begin
            wait_resp(20, cyc);
            chk("t2_b2b_lat", cyc, 4);
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);

        // Wait states; upstream address changes after SETUP must not leak downstream.
        @(negedge clk);
        slv_wait = 5;
        slv_mask = 32'h1234_5678 ^ 32'h1A10_0040;
        set_req(1, 1'b1, 1'b0, 32'h1A10_0040, '0);
        push_exp(1, 32'h1234_5678, 1'b0, 1'b0);
        @(negedge clk);
        addr_hold = bus.apb_paddr_o;
        chk("t3_setup_addr", addr_hold, 32'h1A10_0040);
        bus.req_paddr_i[1] = 32'hFFFF_FFFC;
        cyc = 1;
        while (bus.req_pready_o == '0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.apb_psel_o) chk("t3_addr_stable", bus.apb_paddr_o, 32'h1A10_0040);
        end
        chk("t3_lat", cyc, 8);
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("t3_prdata_hold", bus.req_prdata_o, 32'h1234_5678);

        // Timeout with a slave that never answers.
        slv_wait = 1000;
        set_req(0, 1'b1, 1'b0, 32'h1A10_0080, '0);
        push_exp(0, 32'h0, 1'b1, 1'b1);
        wait_resp(30, cyc);
        chk("t4_lat", cyc, 2 + TO);
        set_req(0, 1'b0, 1'b0, '0, '0);

        // Slave error reported only on the granted index.
        @(negedge clk);
        slv_wait = 0;
        slv_err  = 1'b1;
        slv_mask = 32'hCAFE_0000;
        set_req(1, 1'b1, 1'b1, 32'h1A10_00C0, 32'h0000_00AA);
        push_exp(1, 32'h1A10_00C0 ^ 32'hCAFE_0000, 1'b1, 1'b0);
        wait_resp(20, cyc);
        chk("t5_lat", cyc, 3);
        set_req(1, 1'b0, 1'b0, '0, '0);
        slv_err = 1'b0;

        // Reset during ACCESS, then requester 0 wins first.
        @(negedge clk);
        slv_wait = 1000;
        set_req(0, 1'b1, 1'b0, 32'h1A10_0100, '0);
        repeat (2) @(negedge clk);
        chk("t6_in_access", bus.apb_penable_o, 1);
        rst_n = 1'b0;
        #1;
        check_zero("t6_rst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        slv_wait = 0;
        slv_mask = 32'h0000_FFFF;
        set_req(1, 1'b1, 1'b0, 32'h1A10_0200, '0);
        push_exp(0, 32'h1A10_0100 ^ 32'h0000_FFFF, 1'b0, 1'b0);
        wait_resp(20, cyc);
        chk("t6_lat", cyc, 3);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
